// File: rtl/ifu_fetch.sv
// Instruction fetch unit: in-order fetch queue between the PC register, instruction memory and decode.
// Optional macro IFU_MISALIGN_CHK_EN turns misaligned PCs into local fault entries instead of memory requests.
module ifu_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] curr_pc,
    input  logic              flush,
    output logic              ifu2idu_en,
    output logic              imem_req_vld,
    input  logic              imem_req_rdy,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_vld,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic              idu_vld,
    input  logic              idu_rdy,
    output logic [INST_W-1:0] idu_inst,
    output logic [ADDR_W-1:0] idu_pc,
    output logic              idu_fault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            r_state;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_fptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_unfilled;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [DEPTH-1:0]  r_filled;
    logic [ADDR_W-1:0] r_pc    [DEPTH];
    logic [INST_W-1:0] r_inst  [DEPTH];
    logic              r_fault [DEPTH];

    logic             w_head_vld;
    logic             w_pop;
    logic             w_fill;
    logic             w_full;
    logic             w_can_alloc;
    logic             w_misalign;
    logic             w_mem_acc;
    logic             w_mis_acc;
    logic             w_alloc;
    logic [CNT_W-1:0] w_count_post_pop;
    logic [CNT_W-1:0] w_unfilled_post_fill;
    logic [CNT_W-1:0] w_outstanding;
    logic [CNT_W-1:0] w_flush_drop;
    state_t           w_resume;

    assign w_head_vld = (r_count != '0) && r_filled[r_rptr];
    assign idu_vld    = rst_n & ~flush & w_head_vld;
    assign w_pop      = idu_vld & idu_rdy;
    // Responses only fill when nothing is being drained and an entry is waiting for one.
    assign w_fill     = rst_n & ~flush & imem_rsp_vld & (r_drop_cnt == '0) & (r_unfilled != '0);

    assign w_count_post_pop     = r_count - CNT_W'(w_pop);
    assign w_unfilled_post_fill = r_unfilled - CNT_W'(w_fill);
    assign w_full               = (w_count_post_pop == CNT_DEPTH);
    assign w_can_alloc          = rst_n & (r_state == FETCH) & enable & ~flush & ~w_full;

`ifdef IFU_MISALIGN_CHK_EN
    assign w_misalign = (curr_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign imem_req_vld  = w_can_alloc & ~w_misalign;
    assign w_mem_acc     = imem_req_vld & imem_req_rdy;
    // A self-filled entry may only be created once all older entries are filled, keeping fill order intact.
    assign w_mis_acc     = w_can_alloc & w_misalign & (w_unfilled_post_fill == '0);
    assign w_alloc       = w_mem_acc | w_mis_acc;
    assign ifu2idu_en    = w_alloc;
    assign imem_req_addr = rst_n ? curr_pc : '0;

    assign idu_inst  = idu_vld ? r_inst[r_rptr]  : '0;
    assign idu_pc    = idu_vld ? r_pc[r_rptr]    : '0;
    assign idu_fault = idu_vld ? r_fault[r_rptr] : 1'b0;

    // Everything still owed by memory must be discarded after a redirect.
    assign w_outstanding = r_unfilled + r_drop_cnt;
    assign w_flush_drop  = w_outstanding - CNT_W'(imem_rsp_vld && (w_outstanding != '0));
    assign w_resume      = enable ? FETCH : IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_fptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_drop_cnt <= '0;
            r_filled   <= '0;
        end else if (flush) begin
            r_state    <= (w_flush_drop != '0) ? DRAIN : w_resume;
            r_wptr     <= '0;
            r_fptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            r_drop_cnt <= w_flush_drop;
            r_filled   <= '0;
        end else begin
            if (w_pop) begin
                r_filled[r_rptr] <= 1'b0;
                r_rptr           <= r_rptr + PTR_W'(1);
            end
            if (w_fill) begin
                r_filled[r_fptr] <= 1'b1;
            end
            // Placed after the pop so a same-slot allocate on a full queue wins.
            if (w_alloc) begin
                r_filled[r_wptr] <= w_mis_acc;
                r_wptr           <= r_wptr + PTR_W'(1);
            end
            r_fptr     <= r_fptr + PTR_W'(w_fill) + PTR_W'(w_mis_acc);
            r_count    <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
            r_unfilled <= r_unfilled + CNT_W'(w_mem_acc) - CNT_W'(w_fill);
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_vld && (r_drop_cnt != '0)) begin
                        r_drop_cnt <= r_drop_cnt - CNT_ONE;
                    end
                    if ((r_drop_cnt == '0) || (imem_rsp_vld && (r_drop_cnt == CNT_ONE))) begin
                        r_state <= w_resume;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_pc[r_wptr] <= curr_pc;
            if (w_mis_acc) begin
                r_inst[r_wptr]  <= NOP_INST;
                r_fault[r_wptr] <= 1'b1;
            end
        end
        if (w_fill) begin
            r_inst[r_fptr]  <= imem_rsp_data;
            r_fault[r_fptr] <= imem_rsp_err;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: 1-cycle memory model with hold control, PC-register model and decode scoreboard.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] curr_pc;
    logic        flush;
    logic        ifu2idu_en;
    logic        imem_req_vld;
    logic        imem_req_rdy;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_vld;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        idu_vld;
    logic        idu_rdy;
    logic [31:0] idu_inst;
    logic [31:0] idu_pc;
    logic        idu_fault;

    always #5 clk = ~clk;

    ifu_fetch #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .curr_pc       (curr_pc),
        .flush         (flush),
        .ifu2idu_en    (ifu2idu_en),
        .imem_req_vld  (imem_req_vld),
        .imem_req_rdy  (imem_req_rdy),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_vld  (imem_rsp_vld),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .idu_vld       (idu_vld),
        .idu_rdy       (idu_rdy),
        .idu_inst      (idu_inst),
        .idu_pc        (idu_pc),
        .idu_fault     (idu_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pend[$];
    int          total = 0;
    int          bad   = 0;
    int          n_acc = 0;
    int          acc0;
    bit          mem_hold = 1'b0;
    bit          pc_auto  = 1'b1;
    logic [31:0] err_addr = 32'hFFFF_FFF0;

    logic        s_req_vld, s_en, s_idu_vld, s_fault;
    logic [31:0] s_addr, s_inst, s_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at negedge, score, then drive memory response and PC after the edge.
    task automatic step();
        exp_t        e;
        logic [31:0] a;
        @(negedge clk);
        s_req_vld = imem_req_vld;
        s_en      = ifu2idu_en;
        s_addr    = imem_req_addr;
        s_idu_vld = idu_vld;
        s_inst    = idu_inst;
        s_pc      = idu_pc;
        s_fault   = idu_fault;
        if (ifu2idu_en) n_acc++;
        if (imem_req_vld && imem_req_rdy) pend.push_back(curr_pc);
        if (sb.size() == 0) begin
            chk("idu_vld_when_empty", idu_vld, 32'd0);
        end else if (idu_vld && idu_rdy) begin
            e = sb.pop_front();
            chk("idu_pc", idu_pc, e.pc);
            chk("idu_inst", idu_inst, e.inst);
            chk("idu_fault", idu_fault, e.fault);
            $display("pop pc=0x%08h inst=0x%08h fault=%0d", idu_pc, idu_inst, idu_fault);
        end
        if (flush || !rst_n) sb.delete();
        if (rst_n && !flush && ifu2idu_en) begin
            e.pc    = curr_pc;
            e.inst  = mem_data(curr_pc);
            e.fault = (curr_pc == err_addr);
`ifdef IFU_MISALIGN_CHK_EN
            if (curr_pc[1:0] != 2'b00) begin
                e.inst  = 32'h0000_0013;
                e.fault = 1'b1;
            end
`endif
            sb.push_back(e);
            $display("fetch pc=0x%08h", curr_pc);
        end
        @(posedge clk);
        #1;
        if (!mem_hold && pend.size() != 0) begin
            a             = pend.pop_front();
            imem_rsp_vld  = 1'b1;
            imem_rsp_data = mem_data(a);
            imem_rsp_err  = (a == err_addr);
        end else begin
            imem_rsp_vld  = 1'b0;
            imem_rsp_data = 32'd0;
            imem_rsp_err  = 1'b0;
        end
        if (pc_auto && s_en) curr_pc = curr_pc + 32'd4;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; curr_pc = 32'h40; flush = 1'b0;
        imem_req_rdy = 1'b1; idu_rdy = 1'b1;
        imem_rsp_vld = 1'b0; imem_rsp_data = 32'd0; imem_rsp_err = 1'b0;

        // Reset: every output held low.
        step();
        chk("rst_req_vld", s_req_vld, 0); chk("rst_req_addr", s_addr, 0);
        chk("rst_en", s_en, 0); chk("rst_idu_vld", s_idu_vld, 0);
        chk("rst_idu_inst", s_inst, 0); chk("rst_idu_pc", s_pc, 0); chk("rst_idu_fault", s_fault, 0);
        step();

        // Two sequential fetches with a 1-cycle memory.
        rst_n = 1'b1; curr_pc = 32'h0; acc0 = n_acc;
        step(); chk("idle_no_req", s_req_vld, 0);
        step(); chk("acc0_en", s_en, 1); chk("acc0_addr", s_addr, 32'h0);
        step(); chk("acc1_addr", s_addr, 32'h4); chk("vld_not_same_cycle", s_idu_vld, 0);
        enable = 1'b0;
        step(); chk("d0_vld", s_idu_vld, 1); chk("d0_pc", s_pc, 32'h0); chk("d0_inst", s_inst, 32'hC0DE_0000);
        step(); chk("d1_vld", s_idu_vld, 1); chk("d1_pc", s_pc, 32'h4);
        step(); chk("d_after_vld", s_idu_vld, 0); chk("two_accepts", n_acc - acc0, 2);

        // Back-pressure from decode fills the queue.
        curr_pc = 32'h100; idu_rdy = 1'b0; enable = 1'b1; acc0 = n_acc;
        step();
        step(); chk("bp_acc0", s_addr, 32'h100);
        step();
        step(); chk("bp_full0", s_req_vld, 0);
        step(); chk("bp_full1", s_req_vld, 0);
        idu_rdy = 1'b1;
        step(); chk("bp_pop_alloc", s_req_vld, 1); chk("bp_pop_addr", s_addr, 32'h108);
        idu_rdy = 1'b0;
        step(); chk("bp_full2", s_req_vld, 0);
        step(); chk("bp_full3", s_req_vld, 0); chk("bp_accepts", n_acc - acc0, 3);
        enable = 1'b0; idu_rdy = 1'b1;
        repeat (4) step();

        // Flush with two unfilled entries: drain two responses, then refetch.
        mem_hold = 1'b1; curr_pc = 32'h200; enable = 1'b1;
        step(); step(); step();
        step(); chk("fl_full", s_req_vld, 0);
        flush = 1'b1; curr_pc = 32'h300;
        step(); chk("fl_idu_vld", s_idu_vld, 0); chk("fl_req_vld", s_req_vld, 0); chk("fl_en", s_en, 0);
        flush = 1'b0; mem_hold = 1'b0;
        step(); chk("drain_req0", s_req_vld, 0);
        step(); chk("drain_req1", s_req_vld, 0); chk("drain_vld1", s_idu_vld, 0);
        step(); chk("drain_req2", s_req_vld, 0); chk("drain_vld2", s_idu_vld, 0);
        step(); chk("resume_req", s_req_vld, 1); chk("resume_addr", s_addr, 32'h300);
        enable = 1'b0;
        step();
        step(); chk("resume_vld", s_idu_vld, 1); chk("resume_pc", s_pc, 32'h300);
        step();

        // Flush coinciding with a response and a decode handshake.
        curr_pc = 32'h400; idu_rdy = 1'b0; enable = 1'b1;
        step(); step(); step();
        flush = 1'b1; idu_rdy = 1'b1; curr_pc = 32'h500;
        step(); chk("flrsp_vld", s_idu_vld, 0); chk("flrsp_req", s_req_vld, 0); chk("flrsp_en", s_en, 0);
        flush = 1'b0;
        step(); chk("flrsp_no_drain", s_req_vld, 1); chk("flrsp_addr", s_addr, 32'h500);
        enable = 1'b0;
        step();
        step(); chk("flrsp_out_vld", s_idu_vld, 1); chk("flrsp_out_pc", s_pc, 32'h500);
        step();

        // Access fault from memory.
        err_addr = 32'h8; curr_pc = 32'h8; enable = 1'b1;
        step();
        step(); chk("err_acc", s_addr, 32'h8);
        enable = 1'b0;
        step();
        step(); chk("err_vld", s_idu_vld, 1); chk("err_pc", s_pc, 32'h8); chk("err_fault", s_fault, 1);
        step();

        // Misaligned PC.
        curr_pc = 32'h6; enable = 1'b1;
        step();
`ifdef IFU_MISALIGN_CHK_EN
        step(); chk("mis_no_req", s_req_vld, 0); chk("mis_en", s_en, 1);
        enable = 1'b0;
        step(); chk("mis_vld", s_idu_vld, 1); chk("mis_inst", s_inst, 32'h13);
        chk("mis_fault", s_fault, 1); chk("mis_pc", s_pc, 32'h6);
        step();
`else
        step(); chk("mis_req", s_req_vld, 1); chk("mis_addr", s_addr, 32'h6);
        enable = 1'b0;
        step();
        step(); chk("mis_vld", s_idu_vld, 1); chk("mis_pc", s_pc, 32'h6); chk("mis_fault", s_fault, 0);
`endif
        step();

        // Reset with two fetches in flight; late responses are ignored.
        mem_hold = 1'b1; curr_pc = 32'h600; enable = 1'b1;
        step(); step(); step();
        rst_n = 1'b0;
        step(); chk("mrst_req", s_req_vld, 0); chk("mrst_addr", s_addr, 0);
        chk("mrst_en", s_en, 0); chk("mrst_vld", s_idu_vld, 0);
        rst_n = 1'b1; enable = 1'b0; mem_hold = 1'b0;
        step(); chk("prst_vld", s_idu_vld, 0); chk("prst_inst", s_inst, 0);
        chk("prst_pc", s_pc, 0); chk("prst_fault", s_fault, 0); chk("prst_req", s_req_vld, 0);
        step(); chk("late_vld0", s_idu_vld, 0);
        step(); chk("late_vld1", s_idu_vld, 0);
        step(); chk("late_vld2", s_idu_vld, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
